// File: rtl/mem_arbiter.sv
// Two-port (fetch/data) arbiter sharing one synchronous memory through an IDLE/ACC/RESP FSM.
// Define MEM_ARB_ROUND_ROBIN_EN for round-robin arbitration; by default data has fixed priority.
module mem_arbiter (
  input  logic        clk,
  input  logic        clr,
  input  logic        if_req,
  input  logic [7:0]  if_addr,
  output logic        if_gnt,
  output logic        if_rvalid,
  output logic [31:0] if_rdata,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [7:0]  d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_gnt,
  output logic        d_rvalid,
  output logic [31:0] d_rdata,
  output logic        mem_en,
  output logic        mem_wen,
  output logic [7:0]  mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  output logic        busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_next;
  logic        r_winner;
  logic        r_we;
  logic [7:0]  r_addr;
  logic [31:0] r_wdata;
  logic [31:0] r_if_rdata;
  logic [31:0] r_d_rdata;
  logic        w_any_req;
  logic        w_pick_d;

  assign w_any_req = if_req | d_req;

`ifdef MEM_ARB_ROUND_ROBIN_EN
  // r_last_d: 1 when the data port won the most recent grant
  logic r_last_d;

  assign w_pick_d = d_req & (~if_req | ~r_last_d);

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      r_last_d <= 1'b0;
    end else if (r_state == IDLE && w_any_req) begin
      r_last_d <= w_pick_d;
    end
  end
`else
  assign w_pick_d = d_req;
`endif

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      r_state    <= IDLE;
      r_winner   <= 1'b0;
      r_we       <= 1'b0;
      r_addr     <= 8'h00;
      r_wdata    <= 32'h0;
      r_if_rdata <= 32'h0;
      r_d_rdata  <= 32'h0;
    end else begin
      r_state <= w_next;
      if (r_state == IDLE && w_any_req) begin
        r_winner <= w_pick_d;
        r_we     <= w_pick_d & d_we;
        r_addr   <= w_pick_d ? d_addr : if_addr;
        if (w_pick_d) begin
          r_wdata <= d_wdata;
        end
      end
      if (r_state == RESP) begin
        if (r_winner) begin
          r_d_rdata <= mem_rdata;
        end else begin
          r_if_rdata <= mem_rdata;
        end
      end
    end
  end

  // Strobes are decoded from state so an asynchronous reset drops them immediately
  always_comb begin
    w_next    = r_state;
    mem_en    = 1'b0;
    mem_wen   = 1'b0;
    if_gnt    = 1'b0;
    d_gnt     = 1'b0;
    if_rvalid = 1'b0;
    d_rvalid  = 1'b0;
    if_rdata  = r_if_rdata;
    d_rdata   = r_d_rdata;
    case (r_state)
      IDLE: begin
        if (w_any_req) begin
          w_next = ACC;
        end
      end
      ACC: begin
        mem_en  = 1'b1;
        mem_wen = r_we;
        if (r_winner) begin
          d_gnt = 1'b1;
        end else begin
          if_gnt = 1'b1;
        end
        w_next = r_we ? IDLE : RESP;
      end
      RESP: begin
        if (r_winner) begin
          d_rvalid = 1'b1;
          d_rdata  = mem_rdata;
        end else begin
          if_rvalid = 1'b1;
          if_rdata  = mem_rdata;
        end
        w_next = IDLE;
      end
      default: begin
        w_next = IDLE;
      end
    endcase
  end

  assign mem_addr  = r_addr;
  assign mem_wdata = r_wdata;
  assign busy      = (r_state != IDLE);

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: stimulus pushes expected accesses, a negedge monitor checks them.
// Expected grant order follows MEM_ARB_ROUND_ROBIN_EN when defined.
module tb_mem_arbiter;

  logic        clk;
  logic        clr;
  logic        if_req;
  logic [7:0]  if_addr;
  logic        if_gnt;
  logic        if_rvalid;
  logic [31:0] if_rdata;
  logic        d_req;
  logic        d_we;
  logic [7:0]  d_addr;
  logic [31:0] d_wdata;
  logic        d_gnt;
  logic        d_rvalid;
  logic [31:0] d_rdata;
  logic        mem_en;
  logic        mem_wen;
  logic [7:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        busy;

  typedef struct {
    logic        port;
    logic        we;
    logic [7:0]  addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
  } access_t;

  access_t     accQ[$];
  logic [31:0] memArr[256];
  int          checks;
  int          failures;
  logic        prevRead;
  logic        prevPort;
  logic [31:0] prevData;
  logic [31:0] lastIf;
  logic [31:0] lastD;

  mem_arbiter dut (
    .clk(clk), .clr(clr),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .mem_en(mem_en), .mem_wen(mem_wen), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous memory model: read data appears the cycle after the access
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_wen) begin
        memArr[mem_addr] <= mem_wdata;
      end else begin
        mem_rdata <= memArr[mem_addr];
      end
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic pushAcc(input logic port, input logic we, input logic [7:0] addr,
                         input logic [31:0] wdata, input logic [31:0] rdata);
    access_t a;
    a.port = port;
    a.we = we;
    a.addr = addr;
    a.wdata = wdata;
    a.rdata = rdata;
    accQ.push_back(a);
  endtask

  // Raise a request, wait (bounded) for its grant, then drop req at that negedge
  task automatic applyStimulus(input logic port, input logic we, input logic [7:0] addr,
                               input logic [31:0] wdata);
    bit granted;
    granted = 1'b0;
    if (port) begin
      d_req = 1'b1; d_we = we; d_addr = addr; d_wdata = wdata;
    end else begin
      if_req = 1'b1; if_addr = addr;
    end
    for (int i = 0; i < 50 && !granted; i++) begin
      @(negedge clk);
      granted = port ? d_gnt : if_gnt;
    end
    if (!granted) begin
      checks++;
      failures++;
      $display("[TB] FAIL grantTimeout actual=none expected=gnt port=%0d addr=%h", port, addr);
    end
    if (port) d_req = 1'b0;
    else if_req = 1'b0;
  endtask

  // Monitor: pops expected accesses on mem_en and checks the response the next cycle
  always @(negedge clk) begin
    if (!clr) begin
      accQ.delete();
      prevRead = 1'b0;
      lastIf = 32'h0;
      lastD = 32'h0;
    end else begin
      if (prevRead) begin
        checkOutput("rvalidPort", 32'({if_rvalid, d_rvalid}), prevPort ? 32'h1 : 32'h2);
        if (prevPort) begin
          checkOutput("dRdata", d_rdata, prevData);
          lastD = prevData;
        end else begin
          checkOutput("ifRdata", if_rdata, prevData);
          lastIf = prevData;
        end
      end else begin
        checkOutput("noRvalid", 32'({if_rvalid, d_rvalid}), 32'h0);
        checkOutput("ifRdataHold", if_rdata, lastIf);
        checkOutput("dRdataHold", d_rdata, lastD);
      end
      prevRead = 1'b0;
      if (mem_en) begin
        if (accQ.size() == 0) begin
          checks++;
          failures++;
          $display("[TB] FAIL unexpectedAccess actual=addr %h expected=no access", mem_addr);
        end else begin
          access_t e;
          e = accQ.pop_front();
          checkOutput("grantPort", 32'({if_gnt, d_gnt}), e.port ? 32'h1 : 32'h2);
          checkOutput("memWen", 32'(mem_wen), 32'(e.we));
          checkOutput("memAddr", 32'(mem_addr), 32'(e.addr));
          checkOutput("busyAcc", 32'(busy), 32'h1);
          if (e.we) begin
            checkOutput("memWdata", mem_wdata, e.wdata);
          end else begin
            prevRead = 1'b1;
            prevPort = e.port;
            prevData = e.rdata;
          end
        end
      end else begin
        checkOutput("noGntOutsideAcc", 32'({if_gnt, d_gnt, mem_wen}), 32'h0);
      end
    end
  end

  initial begin
    checks = 0;
    failures = 0;
    prevRead = 1'b0;
    prevPort = 1'b0;
    prevData = 32'h0;
    lastIf = 32'h0;
    lastD = 32'h0;
    mem_rdata = 32'h0;
    for (int i = 0; i < 256; i++) memArr[i] = 32'h0;
    memArr[8'h04] = 32'h2002000A;
    memArr[8'h08] = 32'h11110008;
    memArr[8'h09] = 32'h11110009;
    memArr[8'h20] = 32'h22220020;
    memArr[8'h21] = 32'h22220021;
    clr = 1'b0;
    if_req = 1'b0; if_addr = 8'h00;
    d_req = 1'b0; d_we = 1'b0; d_addr = 8'h00; d_wdata = 32'h0;

    // Reset state
    repeat (2) @(negedge clk);
    checkOutput("rstOutputs", 32'({if_gnt, if_rvalid, d_gnt, d_rvalid, mem_en, mem_wen, busy}), 32'h0);
    checkOutput("rstMemAddr", 32'(mem_addr), 32'h0);
    checkOutput("rstMemWdata", mem_wdata, 32'h0);
    checkOutput("rstRdata", if_rdata | d_rdata, 32'h0);
    clr = 1'b1;

    // Fetch read with explicit latency
    @(negedge clk);
    pushAcc(1'b0, 1'b0, 8'h04, 32'h0, 32'h2002000A);
    if_req = 1'b1; if_addr = 8'h04;
    @(negedge clk);
    checkOutput("t1Gnt", 32'(if_gnt), 32'h1);
    checkOutput("t1MemEn", 32'(mem_en), 32'h1);
    if_req = 1'b0;
    @(negedge clk);
    checkOutput("t1Rvalid", 32'(if_rvalid), 32'h1);
    checkOutput("t1Rdata", if_rdata, 32'h2002000A);
    checkOutput("t1MemEnResp", 32'(mem_en), 32'h0);
    @(negedge clk);
    checkOutput("t1BusyIdle", 32'(busy), 32'h0);

    // Data write: one ACC cycle then IDLE
    pushAcc(1'b1, 1'b1, 8'h10, 32'hDEADBEEF, 32'h0);
    d_req = 1'b1; d_we = 1'b1; d_addr = 8'h10; d_wdata = 32'hDEADBEEF;
    @(negedge clk);
    checkOutput("t2Gnt", 32'(d_gnt), 32'h1);
    checkOutput("t2MemWen", 32'(mem_wen), 32'h1);
    checkOutput("t2MemWdata", mem_wdata, 32'hDEADBEEF);
    d_req = 1'b0; d_we = 1'b0;
    @(negedge clk);
    checkOutput("t2IdleNoRvalid", 32'({busy, d_rvalid}), 32'h0);

    // Simultaneous single requests
`ifdef MEM_ARB_ROUND_ROBIN_EN
    pushAcc(1'b0, 1'b0, 8'h08, 32'h0, 32'h11110008);
    pushAcc(1'b1, 1'b0, 8'h20, 32'h0, 32'h22220020);
`else
    pushAcc(1'b1, 1'b0, 8'h20, 32'h0, 32'h22220020);
    pushAcc(1'b0, 1'b0, 8'h08, 32'h0, 32'h11110008);
`endif
    fork
      applyStimulus(1'b1, 1'b0, 8'h20, 32'h0);
      applyStimulus(1'b0, 1'b0, 8'h08, 32'h0);
    join
    repeat (3) @(negedge clk);

    // Continuously held reads from both ports
`ifdef MEM_ARB_ROUND_ROBIN_EN
    pushAcc(1'b0, 1'b0, 8'h08, 32'h0, 32'h11110008);
    pushAcc(1'b1, 1'b0, 8'h20, 32'h0, 32'h22220020);
    pushAcc(1'b0, 1'b0, 8'h09, 32'h0, 32'h11110009);
    pushAcc(1'b1, 1'b0, 8'h21, 32'h0, 32'h22220021);
`else
    pushAcc(1'b1, 1'b0, 8'h20, 32'h0, 32'h22220020);
    pushAcc(1'b1, 1'b0, 8'h21, 32'h0, 32'h22220021);
    pushAcc(1'b0, 1'b0, 8'h08, 32'h0, 32'h11110008);
    pushAcc(1'b0, 1'b0, 8'h09, 32'h0, 32'h11110009);
`endif
    fork
      begin
        applyStimulus(1'b1, 1'b0, 8'h20, 32'h0);
        applyStimulus(1'b1, 1'b0, 8'h21, 32'h0);
      end
      begin
        applyStimulus(1'b0, 1'b0, 8'h08, 32'h0);
        applyStimulus(1'b0, 1'b0, 8'h09, 32'h0);
      end
    join
    repeat (3) @(negedge clk);

    // Reset in the ACC cycle of a read aborts it
    pushAcc(1'b0, 1'b0, 8'h08, 32'h0, 32'h11110008);
    if_req = 1'b1; if_addr = 8'h08;
    @(negedge clk);
    checkOutput("t5Gnt", 32'(if_gnt), 32'h1);
    if_req = 1'b0;
    #2 clr = 1'b0;
    #1;
    checkOutput("t5AbortStrobes", 32'({mem_en, mem_wen, if_gnt, d_gnt, busy}), 32'h0);
    checkOutput("t5AbortAddr", 32'(mem_addr), 32'h0);
    checkOutput("t5AbortRdata", if_rdata | d_rdata, 32'h0);
    @(negedge clk);
    checkOutput("t5HeldRvalid", 32'({if_rvalid, d_rvalid}), 32'h0);
    @(negedge clk);
    clr = 1'b1;
    repeat (3) @(negedge clk);

    // Served normally after release; reads back the earlier write
    pushAcc(1'b1, 1'b0, 8'h10, 32'h0, 32'hDEADBEEF);
    applyStimulus(1'b1, 1'b0, 8'h10, 32'h0);
    for (int i = 0; i < 20 && accQ.size() != 0; i++) @(negedge clk);
    repeat (3) @(negedge clk);
    checkOutput("sbDrained", 32'(accQ.size()), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
